lab_dp_sched: RTL and testbench
===============================

# lab_dp_sched

- Round-robin scheduler that shares one registered two-operand logic datapath (OR/XOR stage feeding a NAND stage) among `NREQ` requesters.
- Issue slots are paced by a programmable clock-enable divider.
- Results are returned with the winning requester's ID under a valid/ready handshake with full backpressure.
- Sits between the per-channel input logic and the shared datapath result sink.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; must be at least 2.
- `DIV_W`, 4: width of the issue-rate divider.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NREQ: per-requester request. Requester holds `req` and its operands until granted.
- `in_a` in NREQ: operand A, one bit per requester.
- `in_b` in NREQ: operand B, one bit per requester.
- `gnt` out NREQ: one-hot grant, combinational, same cycle as acceptance.
- `div_cfg` in DIV_W: one issue slot every `div_cfg+1` cycles.
- `out_valid` out 1: result valid.
- `out_ready` in 1: sink accepts the result.
- `out_y` out 1: result, equal to `(a|b) & (a^b)`, which is `a^b`.
- `out_id` out clog2(NREQ): index of the requester that produced `out_y`.
- `busy` out 1: any pipeline stage is valid.

## Operation
- **Slot counter `cnt`:**
  - Free-runs every cycle regardless of stalls.
  - Next value is 0 if `cnt >= div_cfg`, else `cnt+1`.
  - `tick = (cnt == 0)`. With `div_cfg = 0`, every cycle is a tick.
  - If `div_cfg` is lowered below `cnt`, the counter wraps to 0 on the next cycle.
- **Acceptance:**
  - Condition: `accept = tick & |req & s1_ready`.
  - `s1_ready = !s1_v | s2_ready`.
  - `s2_ready = !s2_v | out_ready`.
  - A tick without `accept` is lost. The slot is not deferred.
- **Round-robin:**
  - Pointer `last` holds the most recent grantee.
  - Search starts at `last+1` mod NREQ. The first asserted `req` wins.
  - `gnt` is all-zero when `accept = 0`.
  - `last` updates only on `accept`.
- **Stage 1** (loads on `accept`, else clears `s1_v` when advancing):
  - `s1_v <= 1`
  - `rega <= a|b`
  - `regb <= a^b`
  - `id1 <= winner`
- **Stage 2** (loads when `s2_ready`):
  - `s2_v <= s1_v`
  - `regc <= !(rega & regb)`
  - `id2 <= id1`
- **Outputs:**
  - `out_y = ~regc`
  - `out_valid = s2_v`
  - `out_id = id2`
  - `busy = s1_v | s2_v`
- **Stall:**
  - While `out_valid & !out_ready`: stage 2 holds. Stage 1 holds if valid. No accept occurs if stage 1 is valid.
  - No result is ever dropped or duplicated.
- **Simultaneous events:**
  - The out-handshake and an accept in the same cycle are legal; the pipeline stays full.
  - A requester deasserting `req` in the cycle it would win is simply not considered.

## Timing
- **Reset values:**
  - `s1_v`, `s2_v`, `rega`, `regb`, `regc`, `cnt`, `id1`, `id2`: 0.
  - `last` resets to NREQ-1, so requester 0 has first priority.
  - Resulting outputs: `out_valid = 0`, `busy = 0`, `out_id = 0`, `gnt = 0`.
  - `out_y` resets to 1, because `regc = 0`. `out_y` is don't-care while `out_valid = 0`.
- **Reset mid-operation:** all in-flight results are discarded immediately. No `out_valid` is asserted until a new accept follows reset deassertion.
- **Latency:** accept in cycle T gives `out_valid` at T+2, absent stall.
- **Throughput:** 1 result/cycle at `div_cfg = 0`, otherwise 1 per `div_cfg+1` cycles.

## Structure
- **Shared package `lab_dp_pkg`:**
  - Default `NREQ` and `DIV_W`.
  - `ID_W = $clog2(NREQ)`.
  - Pure function `rr_pick(req, last)` returning the winner index and a found flag.
- **Sub-module `lab_rr_arb`:**
  - Contains the `last` register, the `rr_pick` logic and the one-hot `gnt` decode.
  - Inputs: `req`, `accept`.
  - The top level holds the slot counter and the two-stage datapath pipeline.

## Test plan
- **Reset and first grant.** Deassert `rst_n`, with `div_cfg = 0`, `req = 4'b1111`, all `a = 1`, `b = 0`.
  - `gnt` sequence is 0001, 0010, 0100, 1000, 0001.
  - `out_id` is 0, 1, 2, 3 starting 2 cycles after the first grant.
  - `out_y = 1` throughout.
- **Truth table.** Requester 2 alone, applying (a,b) = 00, 01, 10, 11 on consecutive cycles.
  - `out_y` = 0, 1, 1, 0 with `out_id = 2`.
- **Divider.** `div_cfg = 3`, `req = 4'b0011` held.
  - Grants occur every 4th cycle, alternating 0001 and 0010.
  - `out_valid` pulses once per 4 cycles.
- **Backpressure.** `div_cfg = 0`, `req = 4'b1111`, `out_ready = 0` for 5 cycles, then 1.
  - Exactly 2 accepts occur before the stall, then none.
  - `out_valid` and `out_id` hold during the stall.
  - After release, results resume in order 0, 1, 2, … with no gaps or duplicates.
- **Reset mid-flight.** Pulse `rst_n` low with `s1_v = s2_v = 1`.
  - `out_valid` and `busy` go 0 immediately.
  - The next grant goes to requester 0.
- **`div_cfg` shrink.** Set `div_cfg = 7`; at `cnt = 5`, write `div_cfg = 2`.
  - `cnt` wraps to 0 on the next cycle.
  - Ticks then occur every 3 cycles.

Source files
------------

// File: rtl/lab_dp_pkg.sv
// Shared definitions for the round-robin datapath scheduler.
// Holds default sizing, the pick result type and the round-robin search
// function used by the arbiter.
package lab_dp_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned DIV_W_DEF = 4;
    localparam int unsigned ID_W      = $clog2(NREQ_DEF);

    // Upper bound the search function is written for; NREQ must not exceed it.
    localparam int unsigned MAX_NREQ  = 16;
    localparam int unsigned MAX_ID_W  = 4;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    // First asserted request at or after last+1 (mod n); found=0 if none.
    function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                         input logic [MAX_ID_W-1:0] last,
                                         input int unsigned         n);
        rr_pick_t    res;
        int unsigned k;
        res = '0;
        for (int unsigned i = 1; i <= MAX_NREQ; i++) begin
            k = 32'(last) + i;
            if (k >= n) k = k - n;
            if (i <= n && !res.found && req[MAX_ID_W'(k)]) begin
                res.found = 1'b1;
                res.idx   = MAX_ID_W'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lab_rr_arb.sv
// Round-robin arbiter: keeps the most recent grantee and picks the next
// requester after it.
// Ports: clk, rst_n; req (per-requester request); accept (issue this cycle);
//        gnt (one-hot grant, zero unless accept); winner (index of the pick);
//        found (some request is asserted).
module lab_rr_arb
    import lab_dp_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = ID_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  winner,
    output logic            found
);

    logic [IDW-1:0] last;
    rr_pick_t       pick;
    logic           unused_pick_hi;

    // Search starting just after the previous grantee.
    always_comb begin
        pick = rr_pick(MAX_NREQ'(req), MAX_ID_W'(last), NREQ);
    end

    assign winner         = IDW'(pick.idx);
    assign found          = pick.found;
    assign unused_pick_hi = |(pick.idx >> IDW);

    // One-hot grant decode, only when the slot is actually taken.
    always_comb begin
        gnt = '0;
        if (accept) gnt[winner] = 1'b1;
    end

    // Reset to the last index so requester 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IDW'(NREQ - 1);
        end else if (accept) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/lab_dp_sched.sv
// Round-robin scheduler sharing one two-stage logic datapath among NREQ
// requesters; issue slots paced by a programmable divider; results returned
// with the requester ID under valid/ready.
// Ports: clk, rst_n; req/in_a/in_b (per-requester request and operands);
//        gnt (one-hot grant, same cycle as acceptance); div_cfg (one slot per
//        div_cfg+1 cycles); out_valid/out_ready/out_y/out_id (result
//        handshake); busy (any stage holds a valid entry).
module lab_dp_sched
    import lab_dp_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         in_a,
    input  logic [NREQ-1:0]         in_b,
    output logic [NREQ-1:0]         gnt,
    input  logic [DIV_W-1:0]        div_cfg,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_y,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic                    busy
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [DIV_W-1:0] cnt;
    logic             tick;
    logic             accept;
    logic             found;
    logic [IW-1:0]    winner;
    logic             s1_v, s2_v;
    logic             s1_ready, s2_ready;
    logic             rega, regb, regc;
    logic [IW-1:0]    id1, id2;
    logic             op_a, op_b;

    // Slot counter free-runs; lowering div_cfg below cnt wraps next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt >= div_cfg) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign tick     = (cnt == '0);
    assign s2_ready = !s2_v || out_ready;
    assign s1_ready = !s1_v || s2_ready;
    // rst_n gating keeps gnt quiet while reset is held.
    assign accept   = rst_n && tick && found && s1_ready;

    lab_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IW)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .accept (accept),
        .gnt    (gnt),
        .winner (winner),
        .found  (found)
    );

    assign op_a = in_a[winner];
    assign op_b = in_b[winner];

    // Stage 1: OR/XOR of the winning operands; empties as it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            rega <= 1'b0;
            regb <= 1'b0;
            id1  <= '0;
        end else if (accept) begin
            s1_v <= 1'b1;
            rega <= op_a | op_b;
            regb <= op_a ^ op_b;
            id1  <= winner;
        end else if (s2_ready) begin
            s1_v <= 1'b0;
        end
    end

    // Stage 2: NAND stage; holds while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v <= 1'b0;
            regc <= 1'b0;
            id2  <= '0;
        end else if (s2_ready) begin
            s2_v <= s1_v;
            regc <= !(rega && regb);
            id2  <= id1;
        end
    end

    assign out_y     = ~regc;
    assign out_valid = s2_v;
    assign out_id    = id2;
    assign busy      = s1_v || s2_v;

endmodule

// File: tb/tb_lab_dp_sched.sv
// Self-checking bench for lab_dp_sched: directed scenarios plus a randomized
// phase, checked every cycle against a behavioural model and an in-order
// result scoreboard.
module tb_lab_dp_sched;

    localparam int NREQ = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, in_a, in_b, gnt;
    logic [3:0] div_cfg;
    logic       out_valid, out_ready, out_y, busy;
    logic [1:0] out_id;

    always #5 clk = ~clk;

    lab_dp_sched #(.NREQ(4), .DIV_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_a      (in_a),
        .in_b      (in_b),
        .gnt       (gnt),
        .div_cfg   (div_cfg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_id    (out_id),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: two pipeline slots, slot counter, last grantee.
    typedef struct {
        bit v;
        bit y;
        int id;
    } stage_t;

    stage_t     m_s1, m_s2;
    int         m_cnt;
    int         m_last;
    int         sb[$];
    logic [3:0] last_gnt;
    int         gnt_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        m_cnt  = 0;
        m_last = NREQ - 1;
        m_s1   = '{v: 1'b0, y: 1'b0, id: 0};
        m_s2   = '{v: 1'b0, y: 1'b0, id: 0};
        sb.delete();
    endfunction

    // One clock: check outputs at negedge, then advance the model at posedge.
    task automatic cycle();
        bit tick, s1r, s2r, found, acc;
        int w, e;
        @(negedge clk);
        tick  = (m_cnt == 0);
        s2r   = !m_s2.v || out_ready;
        s1r   = !m_s1.v || s2r;
        found = 1'b0;
        w     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (!found && req[2'(idx)]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        acc = rst_n && tick && found && s1r;
        last_gnt = gnt;
        if (gnt != 4'b0) gnt_seen++;
        chk("gnt", 32'(gnt), acc ? (32'(1) << w) : 32'(0));
        chk("out_valid", 32'(out_valid), 32'(m_s2.v));
        chk("busy", 32'(busy), 32'(m_s1.v | m_s2.v));
        if (m_s2.v) begin
            chk("out_id", 32'(out_id), 32'(m_s2.id));
            chk("out_y", 32'(out_y), 32'(m_s2.y));
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'(1));
            end else begin
                e = sb.pop_front();
                chk("sb_id", 32'(out_id), 32'(e / 2));
                chk("sb_y", 32'(out_y), 32'(e % 2));
            end
        end
        @(posedge clk);
        if (rst_n) begin
            if (acc) sb.push_back(w * 2 + int'(in_a[2'(w)] ^ in_b[2'(w)]));
            if (s2r) m_s2 = m_s1;
            if (acc) begin
                m_s1.v  = 1'b1;
                m_s1.y  = in_a[2'(w)] ^ in_b[2'(w)];
                m_s1.id = w;
                m_last  = w;
            end else if (s2r) begin
                m_s1.v = 1'b0;
            end
            m_cnt = (m_cnt >= int'(div_cfg)) ? 0 : m_cnt + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] gseq [5];
        logic [3:0] ab_a [4];
        logic [3:0] ab_b [4];
        int guard;

        gseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ab_a = '{4'b0000, 4'b0000, 4'b0100, 4'b0100};
        ab_b = '{4'b0000, 4'b0100, 4'b0000, 4'b0100};

        // Reset and first grant
        rst_n     = 1'b0;
        div_cfg   = 4'd0;
        req       = 4'b1111;
        in_a      = 4'b1111;
        in_b      = 4'b0000;
        out_ready = 1'b1;
        gnt_seen  = 0;
        model_reset();
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_out_id", 32'(out_id), 32'(0));
        chk("reset_gnt", 32'(gnt), 32'(0));
        chk("reset_out_y", 32'(out_y), 32'(1));
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("first_gnt_seq", 32'(last_gnt), 32'(gseq[i]));
        end
        for (int i = 0; i < 3; i++) cycle();

        // Truth table on requester 2
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            in_a = ab_a[i];
            in_b = ab_b[i];
            cycle();
        end
        req = 4'b0000;
        for (int i = 0; i < 3; i++) cycle();

        // Divider: one slot every 4 cycles
        div_cfg = 4'd3;
        req     = 4'b0011;
        in_a    = 4'b0001;
        in_b    = 4'b0011;
        for (int i = 0; i < 16; i++) cycle();
        req = 4'b0000;
        for (int i = 0; i < 4; i++) cycle();

        // Backpressure
        div_cfg   = 4'd0;
        req       = 4'b1111;
        in_a      = 4'b1010;
        in_b      = 4'b0110;
        out_ready = 1'b0;
        gnt_seen  = 0;
        for (int i = 0; i < 5; i++) cycle();
        chk("stall_accepts", 32'(gnt_seen), 32'(2));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();

        // Reset mid-flight with both stages valid
        chk("pre_rst_valid", 32'(out_valid), 32'(1));
        chk("pre_rst_busy", 32'(busy), 32'(1));
        do_reset();
        cycle();
        chk("post_rst_gnt", 32'(last_gnt), 32'(1));
        for (int i = 0; i < 3; i++) cycle();

        // div_cfg shrink while cnt is past the new limit
        req     = 4'b0001;
        div_cfg = 4'd7;
        guard   = 0;
        while (m_cnt != 5 && guard < 20) begin
            cycle();
            guard++;
        end
        if (guard >= 20) chk("shrink_reach_cnt5", 32'(m_cnt), 32'(5));
        div_cfg = 4'd2;
        cycle();
        cycle();
        chk("shrink_wrap_tick", 32'(last_gnt), 32'(1));
        for (int i = 0; i < 9; i++) cycle();

        // Randomized traffic with requesters holding until granted
        req = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if (i % 64 == 0) div_cfg = 4'($urandom_range(0, 3));
            req = req & ~last_gnt;
            for (int r = 0; r < NREQ; r++) begin
                if (!req[r] && ($urandom % 2 == 0)) begin
                    req[r]  = 1'b1;
                    in_a[r] = 1'($urandom);
                    in_b[r] = 1'($urandom);
                end
            end
            out_ready = ($urandom % 4) != 0;
            cycle();
        end

        // Drain and confirm nothing left outstanding
        req       = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("sb_drained", 32'(sb.size()), 32'(0));
        chk("drained_busy", 32'(busy), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
